core_pipe_ctrl: RTL and testbench
=================================

Name: core_pipe_ctrl

Overview:
Parametrised run-state and hazard controller for the RV32I pipelined core.
- Sequences power-up (OFF -> BOOT -> RUN) and orderly power-down (RUN -> DRAIN -> OFF).
- In RUN, detects load-use hazards and handles taken-branch squashes and external memory stalls.
- Drives per-stage enable and flush vectors to the PC and to every pipeline register.

Parameters:
NUM_STAGES, 5, pipeline depth including IF; legal range 4..8; stage 0 = IF/PC, 1 = ID, 2 = EX.
REG_ADDR_W, 5, register address width.
BOOT_CYCLES, 4, cycles spent in BOOT; legal range 1..255.
FLUSH_DEPTH, 2, younger stages squashed on a taken branch; legal range 1..NUM_STAGES-2.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
power  in  1  run request; level, already synchronous to clk
id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  destination register of instruction in EX
ex_mem_read  in  1  instruction in EX is a load
branch_taken  in  1  branching unit redirects PC this cycle
ext_stall  in  1  memory not ready; freeze whole pipeline
stage_en  out  NUM_STAGES  bit k: load enable of stage-k register; bit 0 = PC
stage_flush  out  NUM_STAGES  bit k: stage-k register loads a bubble; bit 0 always 0
pc_reset  out  1  PC loads the reset vector
state  out  2  OFF=0, BOOT=1, RUN=2, DRAIN=3

Behaviour:
- Interface:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - Assertion forces state=OFF immediately, independent of clk.
  - On assertion, internal counter=0 and outputs take OFF values.
- State and counter are registered. All other outputs are combinational from the current state and inputs, taking effect in the same cycle.
- OFF:
  - Outputs: stage_en=0, stage_flush = all ones except bit 0, pc_reset=0.
  - power=1 at a clock edge -> BOOT, counter=BOOT_CYCLES-1.
- BOOT:
  - Outputs: stage_en=0, stage_flush as in OFF, pc_reset=1.
  - power=0 -> OFF.
  - Otherwise, counter==0 -> RUN; else counter decrements.
  - BOOT therefore lasts exactly BOOT_CYCLES cycles.
- RUN, default: stage_en = all ones, stage_flush=0, pc_reset=0.
- RUN, load_use term:
  - Definition: ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Priority, highest first: ext_stall, branch_taken, load_use.
- RUN, ext_stall: stage_en=0, stage_flush=0; the pipeline freezes and nothing is lost.
- RUN, branch_taken:
  - stage_en = all ones; the PC loads the target.
  - stage_flush[k]=1 for k=1..FLUSH_DEPTH.
  - A simultaneous load_use is ignored, because the dependent instruction is squashed.
- RUN, load_use:
  - stage_en bits 0 and 1 = 0; PC and IF/ID hold.
  - Bits 2..NUM_STAGES-1 = 1.
  - stage_flush[2]=1, inserting a bubble into EX.
  - The stall repeats every cycle the condition holds.
- RUN, power=0 -> DRAIN, counter=NUM_STAGES-2, so the first DRAIN cycle is included.
  - The branch/hazard outputs of the cycle in which power falls still apply.
- DRAIN outputs:
  - stage_en[0]=0: no new fetch.
  - stage_flush[1]=1; other bits 0.
  - Remaining stage_en bits = 1.
  - branch_taken and load_use are ignored.
- DRAIN sequencing:
  - ext_stall=1: stage_en=0, stage_flush=0, counter holds.
  - Otherwise, counter==0 -> OFF; else counter decrements.
  - power re-asserted during DRAIN does not abort the drain. OFF follows, then BOOT on the next edge.
- DRAIN lasts NUM_STAGES-1 non-stalled cycles.

Optional Feature:
Macro CORE_PIPE_CTRL_PERF_EN.
- Defined: adds three output ports, each 32 bits and saturating at 32'hFFFF_FFFF:
  - perf_stall_cycles: RUN or DRAIN cycles with ext_stall=1.
  - perf_load_use: RUN cycles where load_use wins priority.
  - perf_flushes: RUN cycles where branch_taken wins priority.
- Counter clearing: all three clear on reset and on the BOOT -> RUN transition; they update on the clock edge after the event.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. rst_n low then high, power=1, BOOT_CYCLES=4:
   - State OFF -> BOOT on edge 1.
   - pc_reset=1 for exactly 4 cycles, then RUN.
   - In RUN: stage_en=5'b11111, stage_flush=0.
2. RUN load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1.
   - Response: stage_en=5'b11100, stage_flush=5'b00100.
   - Same stimulus with ex_rd=0: stage_en=5'b11111, no flush.
3. RUN, branch_taken=1 with the load-use stimulus of test 2:
   - stage_en=5'b11111, stage_flush=5'b00110 (FLUSH_DEPTH=2).
4. RUN, ext_stall=1 with branch_taken=1 and load-use:
   - stage_en=0, stage_flush=0.
   - With PERF_EN: perf_stall_cycles increments by 1; the other counters are unchanged.
5. RUN, power 1 -> 0, ext_stall pulsed 2 cycles mid-drain:
   - DRAIN lasts 6 cycles with stage_en=5'b11110 and stage_flush=5'b00010, except stalled cycles, which are all zero.
   - Then OFF.
6. rst_n asserted asynchronously mid-DRAIN:
   - state=0 before the next clk edge.
   - stage_en=0, stage_flush=5'b11110.
   - Perf counters read 0.

Source files
------------

// File: rtl/core_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// core_pipe_ctrl
//
// Run-state and hazard controller for the RV32I pipelined core.
// Sequences power-up (OFF -> BOOT -> RUN) and orderly power-down
// (RUN -> DRAIN -> OFF). In RUN it resolves external stalls, taken-branch
// squashes and load-use hazards into per-stage enable/flush vectors.
//
// Optional feature: define CORE_PIPE_CTRL_PERF_EN to add three saturating
// 32-bit performance counters (perf_stall_cycles, perf_load_use,
// perf_flushes). They clear on reset and on the BOOT -> RUN transition.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   power               run request (level, synchronous to clk)
//   id_rs1/id_rs2       source registers of the instruction in ID
//   id_uses_rs1/_rs2    ID instruction actually reads rs1/rs2
//   ex_rd, ex_mem_read  destination and load flag of the instruction in EX
//   branch_taken        PC is redirected this cycle
//   ext_stall           memory not ready, freeze the whole pipeline
//   stage_en            bit k: load enable of stage-k register (bit 0 = PC)
//   stage_flush         bit k: stage-k register loads a bubble (bit 0 = 0)
//   pc_reset            PC loads the reset vector
//   state               OFF=0, BOOT=1, RUN=2, DRAIN=3 (also the debug view)
//
// Stall contract: ext_stall is a level. While it is high no stage loads and
// nothing is flushed, so every in-flight instruction is preserved; the
// control state (including the drain count) holds with it.
// ---------------------------------------------------------------------------
module core_pipe_ctrl #(
    parameter int NUM_STAGES  = 5,
    parameter int REG_ADDR_W  = 5,
    parameter int BOOT_CYCLES = 4,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  power,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    input  logic                  ext_stall,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_flush,
    output logic                  pc_reset,
    output logic [1:0]            state
`ifdef CORE_PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_load_use,
    output logic [31:0]           perf_flushes
`endif
);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_BOOT  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Holds both BOOT_CYCLES-1 (<=254) and NUM_STAGES-2 (<=6).
    localparam int CNT_W = 8;

    localparam logic [NUM_STAGES-1:0] ALL_ONES    = '1;
    // Every register except the PC holds a bubble while powered down.
    localparam logic [NUM_STAGES-1:0] OFF_FLUSH   = {{(NUM_STAGES-1){1'b1}}, 1'b0};
    // Stages 1..FLUSH_DEPTH hold wrong-path instructions after a redirect.
    localparam logic [NUM_STAGES-1:0] BR_FLUSH    = NUM_STAGES'((1 << (FLUSH_DEPTH + 1)) - 2);
    // PC and IF/ID hold, a bubble enters EX, older stages keep moving.
    localparam logic [NUM_STAGES-1:0] LU_EN       = {{(NUM_STAGES-2){1'b1}}, 2'b00};
    localparam logic [NUM_STAGES-1:0] LU_FLUSH    = NUM_STAGES'(4);
    // No new fetch; ID takes bubbles so only real instructions drain out.
    localparam logic [NUM_STAGES-1:0] DRAIN_EN    = {{(NUM_STAGES-1){1'b1}}, 1'b0};
    localparam logic [NUM_STAGES-1:0] DRAIN_FLUSH = NUM_STAGES'(2);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    assign state = state_q;

    // Next-state and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_OFF: begin
                if (power) begin
                    state_d = S_BOOT;
                    cnt_d   = CNT_W'(BOOT_CYCLES - 1);
                end
            end
            S_BOOT: begin
                if (!power) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RUN: begin
                if (!power) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(NUM_STAGES - 2);
                end
            end
            default: begin // S_DRAIN: power is ignored until the drain completes
                if (!ext_stall) begin
                    if (cnt_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage controls. Priority in RUN: ext_stall, branch_taken, load_use.
    always_comb begin
        stage_en    = '0;
        stage_flush = '0;
        pc_reset    = 1'b0;
        case (state_q)
            S_OFF: begin
                stage_flush = OFF_FLUSH;
            end
            S_BOOT: begin
                stage_flush = OFF_FLUSH;
                pc_reset    = 1'b1;
            end
            S_RUN: begin
                if (ext_stall) begin
                    stage_en = '0;
                end else if (branch_taken) begin
                    // A concurrent load-use is moot: the dependent op is squashed.
                    stage_en    = ALL_ONES;
                    stage_flush = BR_FLUSH;
                end else if (load_use) begin
                    stage_en    = LU_EN;
                    stage_flush = LU_FLUSH;
                end else begin
                    stage_en = ALL_ONES;
                end
            end
            default: begin // S_DRAIN
                if (!ext_stall) begin
                    stage_en    = DRAIN_EN;
                    stage_flush = DRAIN_FLUSH;
                end
            end
        endcase
    end

`ifdef CORE_PIPE_CTRL_PERF_EN
    logic boot_done;
    logic ev_stall, ev_load_use, ev_flush;

    assign boot_done   = (state_q == S_BOOT) && power && (cnt_q == '0);
    assign ev_stall    = ((state_q == S_RUN) || (state_q == S_DRAIN)) && ext_stall;
    assign ev_flush    = (state_q == S_RUN) && !ext_stall && branch_taken;
    assign ev_load_use = (state_q == S_RUN) && !ext_stall && !branch_taken && load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_load_use     <= '0;
            perf_flushes      <= '0;
        end else if (boot_done) begin
            perf_stall_cycles <= '0;
            perf_load_use     <= '0;
            perf_flushes      <= '0;
        end else begin
            if (ev_stall && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (ev_load_use && (perf_load_use != '1)) begin
                perf_load_use <= perf_load_use + 32'd1;
            end
            if (ev_flush && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_pipe_ctrl
//
// Self-checking bench for core_pipe_ctrl: directed power-up, hazard, drain
// and asynchronous-reset sequences followed by randomized traffic, all
// compared against a cycle-level reference model of the run-state rules.
// ---------------------------------------------------------------------------
module tb_core_pipe_ctrl;

    localparam int NS = 5;
    localparam int AW = 5;
    localparam int BC = 4;
    localparam int FD = 2;
    localparam int W  = 2 + NS + NS + 1; // {state, stage_en, stage_flush, pc_reset}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          power = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic          ex_mem_read = 1'b0, branch_taken = 1'b0, ext_stall = 1'b0;
    logic [NS-1:0] stage_en, stage_flush;
    logic          pc_reset;
    logic [1:0]    state;
`ifdef CORE_PIPE_CTRL_PERF_EN
    logic [31:0]   perf_stall_cycles, perf_load_use, perf_flushes;
`endif

    core_pipe_ctrl #(
        .NUM_STAGES (NS),
        .REG_ADDR_W (AW),
        .BOOT_CYCLES(BC),
        .FLUSH_DEPTH(FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .power       (power),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .branch_taken(branch_taken),
        .ext_stall   (ext_stall),
        .stage_en    (stage_en),
        .stage_flush (stage_flush),
        .pc_reset    (pc_reset),
        .state       (state)
`ifdef CORE_PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_load_use    (perf_load_use),
        .perf_flushes     (perf_flushes)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase names and "cycles left in this phase", derived directly from
    // the documented phase lengths.
    int m_phase = 0;     // 0 OFF, 1 BOOT, 2 RUN, 3 DRAIN
    int m_left  = 0;     // BOOT: cycles left; DRAIN: non-stalled cycles left
    longint m_stall = 0, m_lu = 0, m_fl = 0;

    function automatic bit hazard();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [W-1:0] predict();
        logic [NS-1:0] en, fl;
        logic pr;
        en = '0; fl = '0; pr = 1'b0;
        for (int k = 0; k < NS; k++) begin
            case (m_phase)
                0: fl[k] = (k != 0);
                1: begin fl[k] = (k != 0); pr = 1'b1; end
                2: begin
                    if (ext_stall) begin
                        en[k] = 1'b0;
                    end else if (branch_taken) begin
                        en[k] = 1'b1;
                        fl[k] = (k >= 1 && k <= FD);
                    end else if (hazard()) begin
                        en[k] = (k >= 2);
                        fl[k] = (k == 2);
                    end else begin
                        en[k] = 1'b1;
                    end
                end
                default: if (!ext_stall) begin
                    en[k] = (k != 0);
                    fl[k] = (k == 1);
                end
            endcase
        end
        return {2'(m_phase), en, fl, pr};
    endfunction

    function automatic longint sat(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic model_step();
        // Events of the cycle just ended.
        if ((m_phase == 2 || m_phase == 3) && ext_stall) m_stall = sat(m_stall);
        if (m_phase == 2 && !ext_stall && branch_taken) m_fl = sat(m_fl);
        if (m_phase == 2 && !ext_stall && !branch_taken && hazard()) m_lu = sat(m_lu);
        case (m_phase)
            0: if (power) begin m_phase = 1; m_left = BC; end
            1: if (!power) m_phase = 0;
               else begin
                   m_left--;
                   if (m_left == 0) begin
                       m_phase = 2;
                       m_stall = 0; m_lu = 0; m_fl = 0;
                   end
               end
            2: if (!power) begin m_phase = 3; m_left = NS - 1; end
            default: if (!ext_stall) begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_stall = 0; m_lu = 0; m_fl = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply(input logic p, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic u1, input logic u2, input logic [AW-1:0] rd,
                         input logic mr, input logic br, input logic st);
        @(negedge clk);
        power = p; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; branch_taken = br; ext_stall = st;
        #1;
    endtask

    task automatic compare_outputs();
        logic [W-1:0] e;
        exp_q.push_back(predict());
        e = exp_q.pop_front();
        check("state",       32'(state),       32'(e[W-1 -: 2]));
        check("stage_en",    32'(stage_en),    32'(e[W-3 -: NS]));
        check("stage_flush", 32'(stage_flush), 32'(e[NS:1]));
        check("pc_reset",    32'(pc_reset),    32'(e[0]));
`ifdef CORE_PIPE_CTRL_PERF_EN
        check("perf_stall",  perf_stall_cycles, 32'(m_stall));
        check("perf_lu",     perf_load_use,     32'(m_lu));
        check("perf_flush",  perf_flushes,      32'(m_fl));
`endif
    endtask

    task automatic finish_cycle();
        compare_outputs();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle_cycle(input logic p);
        apply(p, 0, 0, 0, 0, 0, 0, 0, 0);
        finish_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic p_rand;

        // Reset state.
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_en",    32'(stage_en), 32'd0);
        check("rst_flush", 32'(stage_flush), 32'b11110);
        check("rst_pcrst", 32'(pc_reset), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Test 1: power-up; BOOT lasts exactly BOOT_CYCLES.
        idle_cycle(1'b1);                       // OFF, power sampled
        for (int i = 0; i < BC; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
            check("boot_pcrst", 32'(pc_reset), 32'd1);
            finish_cycle();
        end
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("run_state", 32'(state), 32'd2);
        check("run_en",    32'(stage_en), 32'b11111);
        finish_cycle();

        // Test 2: load-use and the ex_rd==0 exception.
        apply(1, 5, 0, 1, 0, 5, 1, 0, 0);
        check("lu_en",    32'(stage_en), 32'b11100);
        check("lu_flush", 32'(stage_flush), 32'b00100);
        finish_cycle();
        apply(1, 7, 5, 0, 1, 5, 1, 0, 0);       // via rs2
        finish_cycle();
        apply(1, 0, 0, 1, 0, 0, 1, 0, 0);
        check("lu_x0_en", 32'(stage_en), 32'b11111);
        finish_cycle();
        apply(1, 5, 0, 0, 0, 5, 1, 0, 0);       // match but rs1 unused
        finish_cycle();

        // Test 3: branch beats load-use.
        apply(1, 5, 0, 1, 0, 5, 1, 1, 0);
        check("br_flush", 32'(stage_flush), 32'b00110);
        finish_cycle();

        // Test 4: stall beats everything.
        apply(1, 5, 0, 1, 0, 5, 1, 1, 1);
        check("st_en", 32'(stage_en), 32'd0);
        finish_cycle();
        idle_cycle(1'b1);

        // Test 5: power-down with a 2-cycle stall mid-drain.
        apply(1, 5, 0, 1, 0, 5, 1, 0, 0);       // power falls; hazard still applies
        power = 1'b0; #1;
        finish_cycle();
        idle_cycle(1'b0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1); finish_cycle();
        apply(1, 0, 0, 0, 0, 0, 0, 1, 1); finish_cycle(); // power back: no abort
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("drain_last_state", 32'(state), 32'd3);
        finish_cycle();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("off_after_drain", 32'(state), 32'd0);
        finish_cycle();                         // -> BOOT
        for (int i = 0; i < BC + 3; i++) idle_cycle(1'b1);

        // Test 6: asynchronous reset mid-drain.
        idle_cycle(1'b0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_state", 32'(state), 32'd0);
        check("arst_en",    32'(stage_en), 32'd0);
        check("arst_flush", 32'(stage_flush), 32'b11110);
`ifdef CORE_PIPE_CTRL_PERF_EN
        check("arst_perf", perf_stall_cycles | perf_load_use | perf_flushes, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        p_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) p_rand = ~p_rand;
            apply(p_rand,
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 7) == 0));
            finish_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
